// File: rtl/iteration_display.sv
// iteration_display
//   Converts an 8-bit iteration count to three BCD digits (double-dabble,
//   one bit per clock) and drives a 4-digit multiplexed 7-segment display
//   with leading-zero blanking.
//
// Ports
//   clock_signal  in   system clock, rising edge
//   reset_n       in   asynchronous active-low reset
//   counter[7:0]  in   iteration count to show
//   seg[6:0]      out  segments {g,f,e,d,c,b,a}, active-low, registered
//   an[3:0]       out  digit anodes, active-low, an[0] = units, registered
//   dp            out  decimal point, active-low, always off
//   busy          out  conversion in progress
//   conv_done     out  one-cycle pulse when new digits are latched
module iteration_display #(
    parameter int REFRESH_DIV = 100000
) (
    input  logic       clock_signal,
    input  logic       reset_n,
    input  logic [7:0] counter,
    output logic [6:0] seg,
    output logic [3:0] an,
    output logic       dp,
    output logic       busy,
    output logic       conv_done
);

    localparam int SCAN_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(REFRESH_DIV - 1);
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    typedef enum logic [1:0] {IDLE, SHIFT, LATCH} state_t;

    state_t            r_state, w_next;
    logic [19:0]       r_dd;        // {hundreds, tens, units, binary}
    logic [7:0]        r_cap;       // value being converted
    logic [7:0]        r_last;      // last value shown
    logic [2:0]        r_step;
    logic [3:0]        r_hund, r_tens, r_units;
    logic              r_conv;
    logic [SCAN_W-1:0] r_scan;
    logic [1:0]        r_digit;
    logic [6:0]        r_seg;
    logic [3:0]        r_an;
    logic [11:0]       w_adj;
    logic [6:0]        w_seg;
    logic [3:0]        w_an;

    function automatic logic [3:0] add3(input logic [3:0] nib);
        return (nib >= 4'd5) ? nib + 4'd3 : nib;
    endfunction

    function automatic logic [6:0] enc(input logic [3:0] d);
        case (d)
            4'd0:    enc = 7'h40;
            4'd1:    enc = 7'h79;
            4'd2:    enc = 7'h24;
            4'd3:    enc = 7'h30;
            4'd4:    enc = 7'h19;
            4'd5:    enc = 7'h12;
            4'd6:    enc = 7'h02;
            4'd7:    enc = 7'h78;
            4'd8:    enc = 7'h00;
            4'd9:    enc = 7'h10;
            default: enc = SEG_BLANK;
        endcase
    endfunction

    // ---------------- conversion FSM ----------------
    always_ff @(posedge clock_signal or negedge reset_n) begin
        if (!reset_n) r_state <= IDLE;
        else          r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (counter != r_last) w_next = SHIFT;
            SHIFT:   if (r_step == 3'd7)    w_next = LATCH;
            LATCH:   w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Add-3 correction is applied to the BCD part before each shift.
    assign w_adj = {add3(r_dd[19:16]), add3(r_dd[15:12]), add3(r_dd[11:8])};

    always_ff @(posedge clock_signal or negedge reset_n) begin
        if (!reset_n) begin
            r_dd    <= '0;
            r_cap   <= '0;
            r_last  <= '0;
            r_step  <= '0;
            r_hund  <= '0;
            r_tens  <= '0;
            r_units <= '0;
            r_conv  <= 1'b0;
        end else begin
            r_conv <= 1'b0;
            case (r_state)
                IDLE: if (counter != r_last) begin
                    r_dd   <= {12'd0, counter};
                    r_cap  <= counter;
                    r_step <= '0;
                end
                SHIFT: begin
                    r_dd   <= {w_adj, r_dd[7:0]} << 1;
                    r_step <= r_step + 3'd1;
                end
                LATCH: begin
                    r_hund  <= r_dd[19:16];
                    r_tens  <= r_dd[15:12];
                    r_units <= r_dd[11:8];
                    r_last  <= r_cap;
                    r_conv  <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign busy      = (r_state != IDLE);
    assign conv_done = r_conv;

    // ---------------- display scan ----------------
    always_ff @(posedge clock_signal or negedge reset_n) begin
        if (!reset_n) begin
            r_scan  <= '0;
            r_digit <= '0;
        end else if (r_scan == SCAN_LAST) begin
            r_scan  <= '0;
            r_digit <= r_digit + 2'd1;
        end else begin
            r_scan  <= r_scan + 1'b1;
        end
    end

    always_comb begin
        w_an  = 4'b1111;
        w_seg = SEG_BLANK;
        case (r_digit)
            2'd0: begin
                w_an  = 4'b1110;
                w_seg = enc(r_units);
            end
            2'd1: if (r_hund != 4'd0 || r_tens != 4'd0) begin
                w_an  = 4'b1101;
                w_seg = enc(r_tens);
            end
            2'd2: if (r_hund != 4'd0) begin
                w_an  = 4'b1011;
                w_seg = enc(r_hund);
            end
            default: ;  // digit 3 is never lit
        endcase
    end

    always_ff @(posedge clock_signal or negedge reset_n) begin
        if (!reset_n) begin
            r_seg <= 7'h40;
            r_an  <= 4'b1110;
        end else begin
            r_seg <= w_seg;
            r_an  <= w_an;
        end
    end

    assign seg = r_seg;
    assign an  = r_an;
    assign dp  = 1'b1;

endmodule
